mem_port_arbiter: RTL

//  Shares the single Memory data port between the fetch stage (instruction reads) and the

---
 rtl/mem_port_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory data port between instruction fetch
// and the memory stage, one non-pipelined transaction in flight at a time.
//
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   f_req/f_addr          fetch read request and address (held until f_gnt)
//   f_gnt                 fetch request accepted this cycle
//   f_rvalid/f_rdata      fetch read data pulse / data (held until next pulse)
//   d_req/d_we/d_addr     memory-stage request, store flag, address
//   d_wdata               store data
//   d_gnt                 data request accepted this cycle
//   d_rvalid/d_rdata      load data pulse / data (held until next pulse)
//   mem_write/mem_addr    memory write strobe and address
//   mem_wdata/mem_rdata   memory write data / read data
//   stall_fetch           fetch access pending or in flight
//   stall_memory          data access pending or in flight
module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_fetch,
    output logic              stall_memory
);

    localparam int LAT_W = $clog2(MEM_LATENCY + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_q,   state_d;
    logic              owner_q,   owner_d;
    logic              we_q,      we_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [LAT_W-1:0]  lat_q,     lat_d;
    logic [STV_W-1:0]  starve_q,  starve_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic can_grant;
    logic fetch_forced;
    logic f_gnt_w;
    logic d_gnt_w;
    logic busy;

    // Grants are combinational; gating with reset keeps every output low
    // while reset is held, even if a requester keeps its request up.
    always_comb begin
        can_grant    = ~reset & ((state_q == IDLE) | (state_q == RESP));
        fetch_forced = f_req & (starve_q == STV_MAX);
        d_gnt_w      = can_grant & d_req & ~fetch_forced;
        f_gnt_w      = can_grant & f_req & ~d_gnt_w;
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        lat_d     = lat_q;
        starve_d  = starve_q;
        f_rdata_d = f_rdata_q;
        d_rdata_d = d_rdata_q;

        unique case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                    lat_d   = LAT_INIT;
                end
            end
            WAIT: begin
                if (lat_q == LAT_LAST) begin
                    state_d = RESP;
                    if (owner_q) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        f_rdata_d = mem_rdata;
                    end
                end else begin
                    lat_d = lat_q - LAT_LAST;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A grant in IDLE or RESP overrides the fall-back to IDLE.
        if (d_gnt_w) begin
            state_d = ISSUE;
            owner_d = 1'b1;
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
        end else if (f_gnt_w) begin
            state_d = ISSUE;
            owner_d = 1'b0;
            we_d    = 1'b0;
            addr_d  = f_addr;
        end

        // Counts data grants taken while fetch waits; any fetch grant or
        // a quiet fetch side resets it.
        if (~f_req | f_gnt_w) begin
            starve_d = '0;
        end else if (d_gnt_w & ~(&starve_q)) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lat_q     <= '0;
            starve_q  <= '0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            lat_q     <= lat_d;
            starve_q  <= starve_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // addr_q/wdata_q only change on a grant edge, so the memory pins hold
    // their last value whenever no access is being issued.
    always_comb begin
        busy         = (state_q == ISSUE) | (state_q == WAIT);
        f_gnt        = f_gnt_w;
        d_gnt        = d_gnt_w;
        mem_write    = (state_q == ISSUE) & we_q;
        mem_addr     = addr_q;
        mem_wdata    = wdata_q;
        f_rvalid     = (state_q == RESP) & ~owner_q;
        d_rvalid     = (state_q == RESP) & owner_q;
        f_rdata      = f_rdata_q;
        d_rdata      = d_rdata_q;
        stall_fetch  = ~reset & (f_req | (busy & ~owner_q));
        stall_memory = ~reset & (d_req | (busy & owner_q));
    end

endmodule
